alarm_controller: RTL and testbench
===================================

ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 500000000, edit-mode inactivity timeout in clk cycles (10 s at 50 MHz).
REQ-002 SHALL have parameter PERSIST, default 3, consecutive over-threshold samples required to raise an alarm (range 1..15).
REQ-003 SHALL have parameter HYST, default 2, clear hysteresis in sensor units (range 0..15).
REQ-004 SHALL have parameter BEEP_CYC, default 25000000, buzzer half-period in clk cycles.
REQ-005 SHALL have clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have pul_mode / pul_inc / pul_dec  input  1 each  single-cycle button pulses.
REQ-008 SHALL have data_vld  input  1  single-cycle strobe marking a new sensor sample.
REQ-009 SHALL have temp, rh  input  8 each  sensor sample, unsigned, valid when data_vld=1.
REQ-010 SHALL have I_Temp, I_RH  input  8 each  current thresholds from the threshold register block.
REQ-011 SHALL have mode  output  2  edit mode to the threshold block: 0 NORMAL, 1 EDIT_TEMP, 2 EDIT_RH.
REQ-012 SHALL have thr_inc, thr_dec  output  1 each  gated single-cycle pulses to the threshold block.
REQ-013 SHALL have alarm_temp, alarm_rh  output  1 each  latched alarm flags.
REQ-014 SHALL have buzzer  output  1  audible alarm drive.

Function
REQ-015 Mode FSM SHALL advance NORMAL->EDIT_TEMP->EDIT_RH->NORMAL on each pul_mode, updating mode the cycle after the pulse; encoding 3 is never produced.
REQ-016 thr_inc/thr_dec SHALL be registered copies of pul_inc/pul_dec (1-cycle latency), asserted only when mode!=0.
REQ-017 pul_inc and pul_dec in the same cycle SHALL both be dropped; pul_mode together with pul_inc/pul_dec SHALL advance mode and drop the inc/dec.
REQ-018 Idle counter SHALL clear on any pul_* and in NORMAL, else increment; upon reaching TIMEOUT_CYC-1 in an edit mode, mode SHALL be 0 the next cycle.
REQ-019 Per channel, on data_vld: sample > threshold increments a persistence count saturating at PERSIST; any other sample clears it.
REQ-020 Alarm SHALL set the cycle after the data_vld carrying the PERSIST-th consecutive over-threshold sample.
REQ-021 Set alarm SHALL clear the cycle after a data_vld whose sample satisfies the clear condition (REQ-027); samples between threshold-HYST and threshold hold it.
REQ-022 Threshold comparisons SHALL be 9-bit unsigned (no wrap); thresholds sampled only on data_vld.
REQ-023 Buzzer SHALL be 0 with no alarm or mode!=0; otherwise it rises the cycle after an alarm goes active, then toggles every BEEP_CYC cycles; its phase counter restarts whenever buzzer is forced 0.
REQ-024 Alarm evaluation SHALL continue during edit modes.

Reset
REQ-025 rst SHALL force mode=0, thr_inc=thr_dec=0, alarm_temp=alarm_rh=0, buzzer=0, and all counters to 0 on the next edge, overriding every other event, including mid-edit and mid-beep.

Configuration
REQ-026 Macro ALARM_HYST_EN SHALL select hysteresis.
REQ-027 With ALARM_HYST_EN, clear condition is sample+HYST <= threshold; without it, sample <= threshold and HYST is ignored.

Structure
REQ-028 Package alarm_pkg SHALL hold the mode encodings (MODE_NORMAL/EDIT_TEMP/EDIT_RH) and the mode state typedef.
REQ-029 Per-channel persistence/hysteresis logic SHALL be sub-module alarm_channel, instantiated twice (temp, rh).

Verification (TIMEOUT_CYC=100, PERSIST=3, HYST=2, BEEP_CYC=4)
REQ-030 3x pul_mode -> mode 1,2,0; pul_inc in mode 0 -> no thr_inc; in mode 1 -> one thr_inc, 1 cycle late.
REQ-031 mode 2, no pulses for 100 cycles -> mode=0; pul_inc+pul_dec together -> neither output.
REQ-032 I_Temp=26, temp 27,27,27 -> alarm_temp after 3rd vld; temp 27,25,27,27 -> no alarm.
REQ-033 Alarm set, I_Temp=26: temp 25 -> held (HYST_EN) / cleared (no macro); temp 24 -> cleared.
REQ-034 alarm_rh active, mode 0 -> buzzer toggles every 4 cycles; pul_mode -> buzzer 0; I_RH=1, rh=0 -> 9-bit clear condition evaluated without wrap.
REQ-035 rst asserted mid-beep in mode 1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared mode encodings and helpers for the alarm controller.
package alarm_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL    = 2'd0,
    MODE_EDIT_TEMP = 2'd1,
    MODE_EDIT_RH   = 2'd2
  } mode_e;

  localparam int unsigned CNT_W = 32;

  // Mode sequence on a mode-button press; the unused encoding falls back to NORMAL.
  function automatic mode_e next_mode(input mode_e cur);
    mode_e nxt;
    case (cur)
      MODE_NORMAL:    nxt = MODE_EDIT_TEMP;
      MODE_EDIT_TEMP: nxt = MODE_EDIT_RH;
      MODE_EDIT_RH:   nxt = MODE_NORMAL;
      default:        nxt = MODE_NORMAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One sensor channel: persistence filter and latched alarm with optional clear hysteresis.
// ALARM_HYST_EN selects the hysteresis clear condition (sample + HYST <= threshold).
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int unsigned PERSIST = 3,
  parameter int unsigned HYST    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vld_i,
  input  logic [7:0] sample_i,
  input  logic [7:0] thr_i,
  output logic       alarm_o,
  output logic       alarm_nxt_o
);

  localparam logic [3:0] PERSIST_C = 4'(PERSIST);
  localparam logic [8:0] HYST_C    = 9'(HYST);

  logic [3:0] cnt_q, cnt_d;
  logic       alarm_q, alarm_d;
  logic       over_s, clr_s;
  logic [8:0] sample_ext_s, thr_ext_s;

  assign sample_ext_s = {1'b0, sample_i};
  assign thr_ext_s    = {1'b0, thr_i};
  assign over_s       = (sample_ext_s > thr_ext_s);

  // Widened compare so sample + HYST cannot wrap past the threshold.
`ifdef ALARM_HYST_EN
  assign clr_s = ((sample_ext_s + HYST_C) <= thr_ext_s);
`else
  assign clr_s = (sample_ext_s <= thr_ext_s);
`endif

  // Persistence count and alarm latch next-state.
  always_comb begin
    cnt_d   = cnt_q;
    alarm_d = alarm_q;
    if (vld_i) begin
      if (over_s) begin
        if (cnt_q >= PERSIST_C) begin
          cnt_d = PERSIST_C;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
        if (cnt_q >= (PERSIST_C - 4'd1)) begin
          alarm_d = 1'b1;
        end else begin
          alarm_d = alarm_q;
        end
      end else begin
        cnt_d = 4'd0;
        if (clr_s) begin
          alarm_d = 1'b0;
        end else begin
          alarm_d = alarm_q;
        end
      end
    end else begin
      cnt_d   = cnt_q;
      alarm_d = alarm_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 4'd0;
      alarm_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
    end
  end

  assign alarm_o     = alarm_q;
  assign alarm_nxt_o = alarm_d;

endmodule

// File: rtl/alarm_controller.sv
// Alarm controller: edit-mode FSM with inactivity timeout, gated threshold pulses,
// two alarm channels and buzzer. ALARM_HYST_EN enables clear hysteresis in the channels.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 500000000,
  parameter int unsigned PERSIST     = 3,
  parameter int unsigned HYST        = 2,
  parameter int unsigned BEEP_CYC    = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pul_mode,
  input  logic       pul_inc,
  input  logic       pul_dec,
  input  logic       data_vld,
  input  logic [7:0] temp,
  input  logic [7:0] rh,
  input  logic [7:0] I_Temp,
  input  logic [7:0] I_RH,
  output logic [1:0] mode,
  output logic       thr_inc,
  output logic       thr_dec,
  output logic       alarm_temp,
  output logic       alarm_rh,
  output logic       buzzer
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] BEEP_LAST    = CNT_W'(BEEP_CYC - 1);

  mode_e             mode_q, mode_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic              thr_inc_q, thr_inc_d;
  logic              thr_dec_q, thr_dec_d;
  logic              buz_q, buz_d;
  logic [CNT_W-1:0]  beep_q, beep_d;
  logic              pul_any_s, in_edit_s;
  logic              alarm_t_s, alarm_t_nxt_s, alarm_r_s, alarm_r_nxt_s;
  logic              buz_force_s;

  alarm_channel #(.PERSIST(PERSIST), .HYST(HYST)) u_ch_temp (
    .clk        (clk),
    .rst        (rst),
    .vld_i      (data_vld),
    .sample_i   (temp),
    .thr_i      (I_Temp),
    .alarm_o    (alarm_t_s),
    .alarm_nxt_o(alarm_t_nxt_s)
  );

  alarm_channel #(.PERSIST(PERSIST), .HYST(HYST)) u_ch_rh (
    .clk        (clk),
    .rst        (rst),
    .vld_i      (data_vld),
    .sample_i   (rh),
    .thr_i      (I_RH),
    .alarm_o    (alarm_r_s),
    .alarm_nxt_o(alarm_r_nxt_s)
  );

  assign pul_any_s = pul_mode | pul_inc | pul_dec;
  assign in_edit_s = (mode_q != MODE_NORMAL);

  // Mode FSM, idle timer and gated threshold pulses.
  always_comb begin
    mode_d    = mode_q;
    idle_d    = idle_q;
    thr_inc_d = 1'b0;
    thr_dec_d = 1'b0;

    if (pul_mode) begin
      mode_d = next_mode(mode_q);
    end else if (in_edit_s && (idle_q == TIMEOUT_LAST)) begin
      mode_d = MODE_NORMAL;
    end else begin
      mode_d = mode_q;
    end

    if (pul_any_s || !in_edit_s) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + CNT_W'(1);
    end

    // Conflicting button presses cancel; a mode press swallows inc/dec.
    if (in_edit_s && !pul_mode && (pul_inc != pul_dec)) begin
      thr_inc_d = pul_inc;
      thr_dec_d = pul_dec;
    end else begin
      thr_inc_d = 1'b0;
      thr_dec_d = 1'b0;
    end
  end

  // Buzzer is silent unless an alarm is (and stays) active and the next mode is NORMAL.
  assign buz_force_s = !((alarm_t_s | alarm_r_s) && (alarm_t_nxt_s | alarm_r_nxt_s))
                       || (mode_d != MODE_NORMAL);

  // Buzzer phase counter; toggles on each counter wrap, restarting when forced low.
  always_comb begin
    buz_d  = buz_q;
    beep_d = beep_q;
    if (buz_force_s) begin
      buz_d  = 1'b0;
      beep_d = '0;
    end else begin
      if (beep_q == '0) begin
        buz_d = ~buz_q;
      end else begin
        buz_d = buz_q;
      end
      if (beep_q >= BEEP_LAST) begin
        beep_d = '0;
      end else begin
        beep_d = beep_q + CNT_W'(1);
      end
    end
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_NORMAL;
      idle_q    <= '0;
      thr_inc_q <= 1'b0;
      thr_dec_q <= 1'b0;
      buz_q     <= 1'b0;
      beep_q    <= '0;
    end else begin
      mode_q    <= mode_d;
      idle_q    <= idle_d;
      thr_inc_q <= thr_inc_d;
      thr_dec_q <= thr_dec_d;
      buz_q     <= buz_d;
      beep_q    <= beep_d;
    end
  end

  assign mode       = mode_q;
  assign thr_inc    = thr_inc_q;
  assign thr_dec    = thr_dec_q;
  assign alarm_temp = alarm_t_s;
  assign alarm_rh   = alarm_r_s;
  assign buzzer     = buz_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller (TIMEOUT_CYC=100, PERSIST=3, HYST=2, BEEP_CYC=4).
module tb_alarm_controller;

  localparam int SIG_MODE = 0;
  localparam int SIG_INC  = 1;
  localparam int SIG_DEC  = 2;
  localparam int SIG_AT   = 3;
  localparam int SIG_AR   = 4;
  localparam int SIG_BZ   = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pul_mode = 1'b0, pul_inc = 1'b0, pul_dec = 1'b0, data_vld = 1'b0;
  logic [7:0] temp = 8'd0, rh = 8'd0, I_Temp = 8'd26, I_RH = 8'd50;
  logic [1:0] mode;
  logic       thr_inc, thr_dec, alarm_temp, alarm_rh, buzzer;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    int         sig;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    logic       pm, pi, pd;
    logic [1:0] m;
    logic       inc, dec;
  } mvec_t;
  mvec_t tbl[13];

  always #5 clk = ~clk;

  alarm_controller #(
    .TIMEOUT_CYC(100), .PERSIST(3), .HYST(2), .BEEP_CYC(4)
  ) dut (
    .clk(clk), .rst(rst),
    .pul_mode(pul_mode), .pul_inc(pul_inc), .pul_dec(pul_dec),
    .data_vld(data_vld), .temp(temp), .rh(rh),
    .I_Temp(I_Temp), .I_RH(I_RH),
    .mode(mode), .thr_inc(thr_inc), .thr_dec(thr_dec),
    .alarm_temp(alarm_temp), .alarm_rh(alarm_rh), .buzzer(buzzer)
  );

  function automatic logic [7:0] get_sig(input int sig);
    case (sig)
      SIG_MODE: return {6'd0, mode};
      SIG_INC:  return {7'd0, thr_inc};
      SIG_DEC:  return {7'd0, thr_dec};
      SIG_AT:   return {7'd0, alarm_temp};
      SIG_AR:   return {7'd0, alarm_rh};
      SIG_BZ:   return {7'd0, buzzer};
      default:  return 8'hFF;
    endcase
  endfunction

  task automatic expect_sig(input string tag, input int sig, input logic [7:0] val);
    exp_t e;
    e.tag = tag; e.sig = sig; e.val = val;
    sb.push_back(e);
  endtask

  task automatic expect_all_zero(input string tag);
    for (int s = SIG_MODE; s <= SIG_BZ; s++) expect_sig(tag, s, 8'd0);
  endtask

  // One clock: inputs already driven, expectations already queued for after this edge.
  task automatic tick();
    exp_t e;
    logic [7:0] act;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = get_sig(e.sig);
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s sig=%0d actual=%0d required=%0d", e.tag, e.sig, act, e.val);
      end
    end
    pul_mode = 1'b0; pul_inc = 1'b0; pul_dec = 1'b0; data_vld = 1'b0; rst = 1'b0;
  endtask

  task automatic sample(input logic [7:0] t, input logic [7:0] h);
    data_vld = 1'b1; temp = t; rh = h;
  endtask

  initial begin
    //           pm    pi    pd    mode  inc   dec
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};

    // Reset state
    rst = 1'b1;
    expect_all_zero("reset");
    tick();

    // Mode FSM and threshold pulse gating
    for (int i = 0; i < 13; i++) begin
      pul_mode = tbl[i].pm; pul_inc = tbl[i].pi; pul_dec = tbl[i].pd;
      expect_sig($sformatf("vec%0d_mode", i), SIG_MODE, {6'd0, tbl[i].m});
      expect_sig($sformatf("vec%0d_inc", i),  SIG_INC,  {7'd0, tbl[i].inc});
      expect_sig($sformatf("vec%0d_dec", i),  SIG_DEC,  {7'd0, tbl[i].dec});
      tick();
    end

    // Inactivity timeout from EDIT_RH
    pul_mode = 1'b1; tick();
    pul_mode = 1'b1; expect_sig("to_enter", SIG_MODE, 8'd2); tick();
    for (int k = 1; k <= 99; k++) begin
      if (k == 99) expect_sig("to_hold99", SIG_MODE, 8'd2);
      tick();
    end
    expect_sig("to_expire", SIG_MODE, 8'd0);
    tick();

    // Temp persistence: three consecutive over-threshold samples
    I_Temp = 8'd26;
    sample(8'd27, 8'd0); expect_sig("p1", SIG_AT, 8'd0); tick();
    sample(8'd27, 8'd0); expect_sig("p2", SIG_AT, 8'd0); tick();
    sample(8'd27, 8'd0); expect_sig("p3", SIG_AT, 8'd1); tick();
    sample(8'd25, 8'd0);
`ifdef ALARM_HYST_EN
    expect_sig("hyst25", SIG_AT, 8'd1);
`else
    expect_sig("hyst25", SIG_AT, 8'd0);
`endif
    tick();
    sample(8'd24, 8'd0); expect_sig("clr24", SIG_AT, 8'd0); tick();
    sample(8'd27, 8'd0); expect_sig("brk1", SIG_AT, 8'd0); tick();
    sample(8'd25, 8'd0); expect_sig("brk2", SIG_AT, 8'd0); tick();
    sample(8'd27, 8'd0); expect_sig("brk3", SIG_AT, 8'd0); tick();
    sample(8'd27, 8'd0); expect_sig("brk4", SIG_AT, 8'd0); tick();
    tick();

    // RH alarm and buzzer cadence
    I_RH = 8'd50;
    sample(8'd0, 8'd60); expect_sig("rh1", SIG_AR, 8'd0); tick();
    sample(8'd0, 8'd60); expect_sig("rh2", SIG_AR, 8'd0); tick();
    sample(8'd0, 8'd60); expect_sig("rh3", SIG_AR, 8'd1); expect_sig("bz_set", SIG_BZ, 8'd0); tick();
    for (int k = 1; k <= 12; k++) begin
      expect_sig($sformatf("beep%0d", k), SIG_BZ, (((k - 1) / 4) % 2 == 0) ? 8'd1 : 8'd0);
      tick();
    end
    pul_mode = 1'b1;
    expect_sig("edit_mode", SIG_MODE, 8'd1);
    expect_sig("edit_bz", SIG_BZ, 8'd0);
    expect_sig("edit_ar", SIG_AR, 8'd1);
    tick();
    pul_inc = 1'b1; expect_sig("edit_bz2", SIG_BZ, 8'd0); expect_sig("edit_inc", SIG_INC, 8'd1); tick();

    // Reset overrides everything mid-edit
    rst = 1'b1; pul_inc = 1'b1; sample(8'd99, 8'd60);
    expect_all_zero("rst_mid");
    tick();

    // RH clear evaluated in 9 bits
    I_RH = 8'd1;
    sample(8'd0, 8'd255); tick();
    sample(8'd0, 8'd255); tick();
    sample(8'd0, 8'd255); expect_sig("w_set", SIG_AR, 8'd1); tick();
    sample(8'd0, 8'd0);
`ifdef ALARM_HYST_EN
    expect_sig("w_clr0", SIG_AR, 8'd1);
`else
    expect_sig("w_clr0", SIG_AR, 8'd0);
`endif
    tick();
    I_RH = 8'd2;
    sample(8'd0, 8'd0); expect_sig("w_clr2", SIG_AR, 8'd0); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
